// File: rtl/dac_link_pkg.sv
// Shared definitions for the sentinel-framed serial load link: channel FSM states,
// default payload widths and the accept-to-ready frame length.
package dac_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  localparam int VREF_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  // Cycles from the accept edge until ready is seen high again.
  function automatic int frame_cycles(input int w, input int cpb, input int gap);
    return (1 + w) * cpb + gap + 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_ch.sv
// One serial link channel: start '1' then payload LSB first, then a low gap; ready only in IDLE.
// Accept-to-ready is frame_cycles(W,CLKS_PER_BIT,IDLE_GAP); valid while busy is dropped, not queued.
module serial_frame_tx_ch
  import dac_link_pkg::*;
#(
  parameter int W            = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_GAP     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_word,
  input  logic         i_valid,
  output logic         o_ready,
  output logic         o_sdo,
  output logic         o_done
);

  localparam int BW = $clog2(W + 1);
  localparam int DW = $clog2(CLKS_PER_BIT + 1);
  localparam int GW = $clog2(IDLE_GAP + 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  tx_state_e     r_state, w_state_nxt;
  logic [W-1:0]  r_word, w_word_nxt;
  logic [BW-1:0] r_bit_cnt, w_bit_nxt;
  logic [DW-1:0] r_div_cnt, w_div_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_nxt;
  logic          r_sdo, w_sdo_nxt;
  logic          r_done, w_done_nxt;
  logic          w_div_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_gap_cnt <= '0;
      r_sdo     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_word    <= w_word_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_div_cnt <= w_div_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_sdo     <= w_sdo_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // sdo/done are computed one state ahead so the registered line matches the state it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_bit_nxt   = r_bit_cnt;
    w_div_nxt   = r_div_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_sdo_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_div_end   = (r_div_cnt == DIV_LAST);
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_state_nxt = ST_START;
          w_word_nxt  = i_word;
          w_div_nxt   = '0;
          w_sdo_nxt   = 1'b1;
        end
      end
      ST_START: begin
        if (w_div_end) begin
          w_state_nxt = ST_SHIFT;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
          w_sdo_nxt   = r_word[0];
          w_word_nxt  = r_word >> 1;
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
          w_sdo_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_div_end) begin
          w_div_nxt = '0;
          if (r_bit_cnt == BIT_LAST) begin
            if (IDLE_GAP == 0) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_GAP;
              w_gap_nxt   = '0;
            end
          end else begin
            w_bit_nxt  = r_bit_cnt + 1'b1;
            w_sdo_nxt  = r_word[0];
            w_word_nxt = r_word >> 1;
          end
        end else begin
          w_div_nxt = r_div_cnt + 1'b1;
          w_sdo_nxt = r_sdo;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_ready = (r_state == ST_IDLE);
  assign o_sdo   = r_sdo;
  assign o_done  = r_done;

endmodule

// File: rtl/dac_frame_tx.sv
// Transmit end of the DAC load link: independent VREF and DATA serial channels plus a busy OR.
// Each channel accepts on valid&&ready and holds ready low for the whole frame and gap.
module dac_frame_tx
  import dac_link_pkg::*;
#(
  parameter int VREF_W       = VREF_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = 1,
  parameter int IDLE_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VREF_W-1:0] vref_in,
  input  logic              vref_valid,
  output logic              vref_ready,
  output logic              vref_sdo,
  output logic              vref_done,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              data_sdo,
  output logic              data_done,
  output logic              busy
);

  serial_frame_tx_ch #(
    .W            (VREF_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .IDLE_GAP     (IDLE_GAP)
  ) u_vref_ch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_word  (vref_in),
    .i_valid (vref_valid),
    .o_ready (vref_ready),
    .o_sdo   (vref_sdo),
    .o_done  (vref_done)
  );

  serial_frame_tx_ch #(
    .W            (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .IDLE_GAP     (IDLE_GAP)
  ) u_data_ch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_word  (data_in),
    .i_valid (data_valid),
    .o_ready (data_ready),
    .o_sdo   (data_sdo),
    .o_done  (data_done)
  );

  assign busy = ~(vref_ready & data_ready);

endmodule

// File: tb/tb_dac_frame_tx.sv
// Directed bench for dac_frame_tx: expected per-cycle line/ready/done values are queued
// when a word is driven and compared against the DUT one cycle at a time.
module tb_dac_frame_tx;

  typedef struct packed {
    logic sdo;
    logic rdy;
    logic done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] vref_in = '0;
  logic       vref_valid = 1'b0;
  logic       vref_ready, vref_sdo, vref_done;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, data_sdo, data_done;
  logic       busy;

  logic [3:0] v6_in = '0;
  logic       v6_valid = 1'b0;
  logic       v6_ready, v6_sdo, v6_done;
  logic       d6_ready, d6_sdo, d6_done, busy6;

  exp_t q_vref[$];
  exp_t q_data[$];
  exp_t q_v6[$];

  int         n_checks = 0;
  int         n_err = 0;
  logic [8:0] rx = '0;

  always #5 clk = ~clk;

  dac_frame_tx #(.VREF_W(4), .DATA_W(8), .CLKS_PER_BIT(1), .IDLE_GAP(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vref_in    (vref_in),
    .vref_valid (vref_valid),
    .vref_ready (vref_ready),
    .vref_sdo   (vref_sdo),
    .vref_done  (vref_done),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_sdo   (data_sdo),
    .data_done  (data_done),
    .busy       (busy)
  );

  dac_frame_tx #(.VREF_W(4), .DATA_W(8), .CLKS_PER_BIT(3), .IDLE_GAP(0)) u_dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .vref_in    (v6_in),
    .vref_valid (v6_valid),
    .vref_ready (v6_ready),
    .vref_sdo   (v6_sdo),
    .vref_done  (v6_done),
    .data_in    (8'h00),
    .data_valid (1'b0),
    .data_ready (d6_ready),
    .data_sdo   (d6_sdo),
    .data_done  (d6_done),
    .busy       (busy6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_e(input int ch, input exp_t e);
    case (ch)
      0:       q_vref.push_back(e);
      1:       q_data.push_back(e);
      default: q_v6.push_back(e);
    endcase
  endtask

  // Start bit, payload LSB first, low gap, then the first idle cycle with ready and done.
  task automatic push_frame(input int ch, input logic [7:0] word, input int w,
                            input int cpb, input int gap);
    for (int c = 0; c < cpb; c++) push_e(ch, '{sdo: 1'b1, rdy: 1'b0, done: 1'b0});
    for (int i = 0; i < w; i++)
      for (int c = 0; c < cpb; c++) push_e(ch, '{sdo: word[i], rdy: 1'b0, done: 1'b0});
    for (int g = 0; g < gap; g++) push_e(ch, '{sdo: 1'b0, rdy: 1'b0, done: 1'b0});
    push_e(ch, '{sdo: 1'b0, rdy: 1'b1, done: 1'b1});
  endtask

  task automatic push_idle(input int ch, input int n);
    for (int k = 0; k < n; k++) push_e(ch, '{sdo: 1'b0, rdy: 1'b1, done: 1'b0});
  endtask

  task automatic step();
    exp_t e;
    logic bv, bd, any;
    @(posedge clk);
    #1;
    bv = 1'b1;
    bd = 1'b1;
    any = 1'b0;
    if (q_vref.size() > 0) begin
      e = q_vref.pop_front();
      chk("vref_sdo", vref_sdo, e.sdo);
      chk("vref_ready", vref_ready, e.rdy);
      chk("vref_done", vref_done, e.done);
      bv = e.rdy;
      any = 1'b1;
    end
    if (q_data.size() > 0) begin
      e = q_data.pop_front();
      chk("data_sdo", data_sdo, e.sdo);
      chk("data_ready", data_ready, e.rdy);
      chk("data_done", data_done, e.done);
      bd = e.rdy;
      any = 1'b1;
    end
    if (any) chk("busy", busy, !(bv && bd));
    if (q_v6.size() > 0) begin
      e = q_v6.pop_front();
      chk("v6_sdo", v6_sdo, e.sdo);
      chk("v6_ready", v6_ready, e.rdy);
      chk("v6_done", v6_done, e.done);
    end
    // Far-end receiver: shifts until the start bit lands in bit 0, then holds.
    if (!rx[0]) rx = {data_sdo, rx[8:1]};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_vref.size() + q_data.size() + q_v6.size()) > 0 && n < 500) begin
      step();
      n++;
    end
  endtask

  initial begin
    // Reset state, asserted asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_vref_sdo", vref_sdo, 1'b0);
    chk("rst_data_sdo", data_sdo, 1'b0);
    chk("rst_vref_ready", vref_ready, 1'b1);
    chk("rst_data_ready", data_ready, 1'b1);
    chk("rst_vref_done", vref_done, 1'b0);
    chk("rst_data_done", data_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(0, 2);
    push_idle(1, 2);
    drain();

    // 1: VREF 4'hA; a valid pulse mid-frame must be ignored.
    vref_in = 4'hA;
    vref_valid = 1'b1;
    push_frame(0, 8'h0A, 4, 1, 2);
    push_idle(0, 3);
    step();
    vref_valid = 1'b0;
    vref_in = 4'h0;
    step();
    vref_in = 4'h3;
    vref_valid = 1'b1;
    step();
    vref_valid = 1'b0;
    drain();

    // 2: loopback of 8'hC3 into the sentinel receiver model.
    rx = '0;
    data_in = 8'hC3;
    data_valid = 1'b1;
    push_frame(1, 8'hC3, 8, 1, 2);
    step();
    data_valid = 1'b0;
    data_in = 8'h00;
    drain();
    chk("rx_data", rx[8:1], 8'hC3);
    chk("rx_stop", rx[0], 1'b1);
    push_idle(1, 3);
    drain();
    chk("rx_hold", rx, {8'hC3, 1'b1});

    // 3: back-to-back with valid held; input change after accept is ignored.
    data_in = 8'h01;
    data_valid = 1'b1;
    push_frame(1, 8'h01, 8, 1, 2);
    push_frame(1, 8'hFF, 8, 1, 2);
    step();
    data_in = 8'hFF;
    for (int k = 0; k < 12; k++) step();
    data_valid = 1'b0;
    push_idle(1, 2);
    drain();

    // 4: simultaneous accept on both channels.
    vref_in = 4'h5;
    data_in = 8'h80;
    vref_valid = 1'b1;
    data_valid = 1'b1;
    push_frame(0, 8'h05, 4, 1, 2);
    push_idle(0, 5);
    push_frame(1, 8'h80, 8, 1, 2);
    push_idle(1, 1);
    step();
    vref_valid = 1'b0;
    data_valid = 1'b0;
    drain();

    // 5: async reset during cycle 4 of a DATA frame, then a clean frame.
    data_in = 8'hFF;
    data_valid = 1'b1;
    push_frame(1, 8'hFF, 8, 1, 2);
    step();
    data_valid = 1'b0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data_sdo", data_sdo, 1'b0);
    chk("arst_data_ready", data_ready, 1'b1);
    chk("arst_data_done", data_done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    q_data.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(1, 3);
    drain();
    data_in = 8'h5A;
    data_valid = 1'b1;
    push_frame(1, 8'h5A, 8, 1, 2);
    step();
    data_valid = 1'b0;
    drain();

    // 6: CLKS_PER_BIT=3, IDLE_GAP=0 instance, 4'hF.
    v6_in = 4'hF;
    v6_valid = 1'b1;
    push_frame(2, 8'h0F, 4, 3, 0);
    push_idle(2, 2);
    step();
    v6_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
